// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the round-robin UART transmit scheduler.
package uart_tx_sched_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_t;

  localparam logic TXD_IDLE  = 1'b1;
  localparam logic START_BIT = 1'b0;

  function automatic int cnt_width(input int data_w);
    return (data_w > 1) ? $clog2(data_w) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester-side bus of the UART transmit scheduler.
interface uart_tx_sched_if
  import uart_tx_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 8
);
  // Handshake: req[i] is a level held with stable intent until ack[i]; the byte
  // is taken from req_data on the cycle grant[i] rises, and ack[i] pulses for one
  // clk when that frame's last stop bit completes (even if req[i] was dropped).
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        ack;
  state_t                    dbg_state;

  modport master (output req, req_data, input grant, ack, dbg_state);
  modport slave  (input req, req_data, output grant, ack, dbg_state);
endinterface

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  input  logic               enable_i,
  output logic [NUM_REQ-1:0] grant_o
);

  always_comb begin : pick
    int idx;
    idx     = 0;
    grant_o = '0;
    if (enable_i) begin
      // Walk from the farthest offset back to the pointer so the nearest wins.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        idx = (int'(ptr_i) + k) % NUM_REQ;
        if (req_i[idx]) grant_o = NUM_REQ'(1) << idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin shared UART transmitter, 8N1-style frames paced by BaudTick.
// Define UART_TX_SCHED_PARITY_EN to insert an even-parity bit before the stop bits.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int DATA_W    = 8,
  parameter int STOP_BITS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            BaudTick,
  uart_tx_sched_if.slave  bus,
  output logic            busy,
  output logic            txd
);

  localparam int CNT_W = cnt_width(DATA_W);
  localparam int PTR_W = $clog2(NUM_REQ);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d, owner_q, owner_d, win_idx;
  logic [NUM_REQ-1:0]  win, grant_q, grant_d, ack_q, ack_d;
  logic                txd_q, txd_d, busy_q, busy_d;
`ifdef UART_TX_SCHED_PARITY_EN
  logic                par_q, par_d;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
    .req_i    (bus.req),
    .ptr_i    (ptr_q),
    .enable_i (state_q == IDLE),
    .grant_o  (win)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) if (win[i]) win_idx = PTR_W'(i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      txd_q   <= TXD_IDLE;
      busy_q  <= 1'b0;
`ifdef UART_TX_SCHED_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
`ifdef UART_TX_SCHED_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
`ifdef UART_TX_SCHED_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: if (|win) begin
        state_d = SYNC;
        owner_d = win_idx;
        shift_d = bus.req_data[win_idx*DATA_W +: DATA_W];
`ifdef UART_TX_SCHED_PARITY_EN
        par_d   = ^bus.req_data[win_idx*DATA_W +: DATA_W];
`endif
      end
      SYNC:  if (BaudTick) state_d = START;
      START: if (BaudTick) begin
        state_d = DATA;
        cnt_d   = '0;
      end
      DATA: if (BaudTick) begin
        shift_d = shift_q >> 1;
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
`ifdef UART_TX_SCHED_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_TX_SCHED_PARITY_EN
      PARITY: if (BaudTick) begin
        state_d = STOP;
        cnt_d   = '0;
      end
`endif
      STOP: if (BaudTick) begin
        if (cnt_q == CNT_W'(STOP_BITS - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          ptr_d   = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the next state so the registered line lines up with it.
  always_comb begin
    txd_d   = TXD_IDLE;
    grant_d = '0;
    ack_d   = '0;
    busy_d  = (state_d != IDLE);
    case (state_d)
      START:  txd_d = START_BIT;
      DATA:   txd_d = shift_d[0];
`ifdef UART_TX_SCHED_PARITY_EN
      PARITY: txd_d = par_d;
`endif
      default: txd_d = TXD_IDLE;
    endcase
    if (state_d != IDLE) grant_d = NUM_REQ'(1) << owner_d;
    if (state_q == STOP && state_d == IDLE) ack_d = NUM_REQ'(1) << owner_q;
  end

  assign bus.grant     = grant_q;
  assign bus.ack       = ack_q;
  assign bus.dbg_state = state_q;
  assign busy          = busy_q;
  assign txd           = txd_q;

endmodule
